// File: rtl/anim_pkg.sv
// Shared types and default reload constants for the sprite animation sequencer.
package anim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StDraw,
        StWaitStep,
        StErase,
        StMove
    } anim_state_e;

    localparam logic [19:0] TickReloadDefault    = 20'd128;
    localparam logic [3:0]  FramesPerStepDefault = 4'd15;

endpackage

// File: rtl/step_timer.sv
// Tick divider plus frame counter producing a one-cycle step strobe.
module step_timer
    import anim_pkg::*;
#(
    parameter logic [19:0] TICK_RELOAD     = TickReloadDefault,
    parameter logic [3:0]  FRAMES_PER_STEP = FramesPerStepDefault
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    output logic step_pulse
);

    logic [19:0] tick_q, tick_d;
    logic [3:0]  frame_q, frame_d;
    logic        tick;

    always_comb begin
        tick       = (tick_q == 20'd0);
        tick_d     = tick_q;
        frame_d    = frame_q;
        step_pulse = 1'b0;
        if (run) begin
            tick_d = tick ? TICK_RELOAD : tick_q - 20'd1;
            if (tick) begin
                if (frame_q == 4'd0) begin
                    frame_d    = FRAMES_PER_STEP;
                    step_pulse = 1'b1;
                end else begin
                    frame_d = frame_q - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            tick_q  <= TICK_RELOAD;
            frame_q <= FRAMES_PER_STEP;
        end else begin
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

endmodule

// File: rtl/anim_sequencer.sv
// Erase-move-draw sequencer for one bouncing sprite; ANIM_PAUSE_EN adds a pause input.
module anim_sequencer
    import anim_pkg::*;
#(
    parameter logic [19:0] TICK_RELOAD     = TickReloadDefault,
    parameter logic [3:0]  FRAMES_PER_STEP = FramesPerStepDefault,
    parameter int unsigned X_W             = 8,
    parameter int unsigned Y_W             = 7,
    parameter int unsigned X_MAX           = 159,
    parameter int unsigned Y_MAX           = 119
) (
    input  logic           clk,
    input  logic           resetn,
`ifdef ANIM_PAUSE_EN
    input  logic           pause,
`endif
    input  logic           go,
    input  logic           stop,
    input  logic           draw_done,
    output logic           draw_req,
    output logic           erase,
    output logic [X_W-1:0] obj_x,
    output logic [Y_W-1:0] obj_y,
    output logic           busy,
    output logic           step_pulse
);

    localparam logic [X_W-1:0] XMax = X_W'(X_MAX);
    localparam logic [Y_W-1:0] YMax = Y_W'(Y_MAX);

    anim_state_e    state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           dx_q, dx_d;  // 1 = moving +
    logic           dy_q, dy_d;
    logic           timer_resetn;
    logic           timer_run;

    // Holding the timer in reset while idle keeps both counters at their reload values.
    assign timer_resetn = resetn && (state_q != StIdle);
`ifdef ANIM_PAUSE_EN
    assign timer_run = (state_q != StIdle) && !pause;
`else
    assign timer_run = (state_q != StIdle);
`endif

    step_timer #(
        .TICK_RELOAD    (TICK_RELOAD),
        .FRAMES_PER_STEP(FRAMES_PER_STEP)
    ) u_step_timer (
        .clk       (clk),
        .resetn    (timer_resetn),
        .run       (timer_run),
        .step_pulse(step_pulse)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        unique case (state_q)
            StIdle: begin
                if (go) begin
                    state_d = StDraw;
                    x_d     = '0;
                    y_d     = '0;
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end
            end
            StDraw: begin
                if (draw_done) state_d = StWaitStep;
            end
            StWaitStep: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (step_pulse) begin
                    state_d = StErase;
                end
            end
            StErase: begin
                if (draw_done) state_d = StMove;
            end
            StMove: begin
                state_d = StDraw;
                if (dx_q) begin
                    if (x_q == XMax) begin
                        dx_d = 1'b0;
                        x_d  = x_q - 1'b1;
                    end else begin
                        x_d = x_q + 1'b1;
                    end
                end else begin
                    if (x_q == '0) begin
                        dx_d = 1'b1;
                        x_d  = x_q + 1'b1;
                    end else begin
                        x_d = x_q - 1'b1;
                    end
                end
                if (dy_q) begin
                    if (y_q == YMax) begin
                        dy_d = 1'b0;
                        y_d  = y_q - 1'b1;
                    end else begin
                        y_d = y_q + 1'b1;
                    end
                end else begin
                    if (y_q == '0) begin
                        dy_d = 1'b1;
                        y_d  = y_q + 1'b1;
                    end else begin
                        y_d = y_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
        end
    end

    assign draw_req = (state_q == StDraw) || (state_q == StErase);
    assign erase    = (state_q == StErase);
    assign busy     = (state_q != StIdle);
    assign obj_x    = x_q;
    assign obj_y    = y_q;

endmodule

// File: tb/tb_anim_sequencer.sv
// Directed bench for anim_sequencer with a draw engine answering 2 cycles after req.
module tb_anim_sequencer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic       stop = 1'b0;
    logic       draw_done = 1'b0;
    logic       draw_req;
    logic       erase;
    logic [7:0] obj_x;
    logic [6:0] obj_y;
    logic       busy;
    logic       step_pulse;
`ifdef ANIM_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    logic stall = 1'b0;
    int eng_cnt = 0;

    always #5 clk = ~clk;

    anim_sequencer #(
        .TICK_RELOAD    (20'd3),
        .FRAMES_PER_STEP(4'd1),
        .X_W            (8),
        .Y_W            (7),
        .X_MAX          (2),
        .Y_MAX          (1)
    ) dut (
`ifdef ANIM_PAUSE_EN
        .pause     (pause),
`endif
        .clk       (clk),
        .resetn    (resetn),
        .go        (go),
        .stop      (stop),
        .draw_done (draw_done),
        .draw_req  (draw_req),
        .erase     (erase),
        .obj_x     (obj_x),
        .obj_y     (obj_y),
        .busy      (busy),
        .step_pulse(step_pulse)
    );

    // Draw engine: done is raised in the third cycle of a request unless stalled.
    always @(negedge clk) begin
        if (draw_req === 1'b1) begin
            eng_cnt   = eng_cnt + 1;
            draw_done = (eng_cnt >= 3) && !stall;
        end else begin
            eng_cnt   = 0;
            draw_done = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next rising edge of draw_req; n is the number of cycles taken.
    task automatic wait_rise(input int budget, output int n);
        n = 0;
        while (draw_req === 1'b1 && n < budget) begin
            step();
            n++;
        end
        while (draw_req !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        chk("wait_req", {31'd0, draw_req}, 32'd1);
    endtask

    int ex[10] = '{0, 1, 1, 2, 2, 1, 1, 0, 0, 1};
    int ey[10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
    int er[10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    int eg[10] = '{8, 4, 4, 4, 4, 4, 4, 4, 4, 4};

    initial begin
        int n;
        int pulses;
        int reqs;

        step();
        step();
        chk("rst_draw_req", {31'd0, draw_req}, 32'd0);
        chk("rst_erase", {31'd0, erase}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_x", {24'd0, obj_x}, 32'd0);
        chk("rst_y", {25'd0, obj_y}, 32'd0);
        chk("rst_step", {31'd0, step_pulse}, 32'd0);
        resetn = 1'b1;
        step();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        go = 1'b1;
        step();
        go = 1'b0;
        chk("go_req", {31'd0, draw_req}, 32'd1);
        chk("go_erase", {31'd0, erase}, 32'd0);
        chk("go_x", {24'd0, obj_x}, 32'd0);
        chk("go_y", {25'd0, obj_y}, 32'd0);
        chk("go_busy", {31'd0, busy}, 32'd1);

        for (int i = 0; i < 10; i++) begin
            wait_rise(40, n);
            chk($sformatf("run%0d_gap", i), n, eg[i]);
            chk($sformatf("run%0d_erase", i), {31'd0, erase}, er[i]);
            chk($sformatf("run%0d_x", i), {24'd0, obj_x}, ex[i]);
            chk($sformatf("run%0d_y", i), {25'd0, obj_y}, ey[i]);
        end

        // Stall the erase of (1,1): request and position must hold, steps are dropped.
        wait_rise(40, n);
        chk("stall_gap", n, 4);
        stall = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (step_pulse === 1'b1) pulses++;
            chk("stall_req", {31'd0, draw_req}, 32'd1);
            chk("stall_erase", {31'd0, erase}, 32'd1);
            chk("stall_x", {24'd0, obj_x}, 32'd1);
            chk("stall_y", {25'd0, obj_y}, 32'd1);
        end
        chk("stall_pulses", pulses, 2);
        stall = 1'b0;
        wait_rise(40, n);
        chk("post_stall_erase", {31'd0, erase}, 32'd0);
        chk("post_stall_x", {24'd0, obj_x}, 32'd2);
        chk("post_stall_y", {25'd0, obj_y}, 32'd0);

        // Stop coinciding with a step in WAIT_STEP.
        n = 0;
        while (!(step_pulse === 1'b1 && draw_req === 1'b0) && n < 40) begin
            step();
            n++;
        end
        chk("stop_pulse_seen", {31'd0, step_pulse}, 32'd1);
        chk("stop_in_wait", {31'd0, draw_req}, 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_busy", {31'd0, busy}, 32'd0);
        chk("stop_req", {31'd0, draw_req}, 32'd0);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (draw_req === 1'b1) reqs++;
        end
        chk("stop_no_erase", reqs, 0);

        // Relaunch: counters restart from reload, steps at exactly 8 and 16 cycles.
        go = 1'b1;
        step();
        go = 1'b0;
        chk("relaunch_x", {24'd0, obj_x}, 32'd0);
        chk("relaunch_y", {25'd0, obj_y}, 32'd0);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i == 7 || i == 15) begin
                chk($sformatf("period_c%0d", i), {31'd0, step_pulse}, 32'd1);
            end else begin
                chk($sformatf("period_c%0d", i), {31'd0, step_pulse}, 32'd0);
            end
        end
        chk("mid_erase_req", {31'd0, draw_req}, 32'd1);
        chk("mid_erase_erase", {31'd0, erase}, 32'd1);

        // One-cycle reset in the middle of the erase request.
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("mreset_req", {31'd0, draw_req}, 32'd0);
        chk("mreset_erase", {31'd0, erase}, 32'd0);
        chk("mreset_busy", {31'd0, busy}, 32'd0);
        chk("mreset_x", {24'd0, obj_x}, 32'd0);
        chk("mreset_y", {25'd0, obj_y}, 32'd0);
        chk("mreset_step", {31'd0, step_pulse}, 32'd0);
        step();
        chk("mreset_idle", {31'd0, busy}, 32'd0);

`ifdef ANIM_PAUSE_EN
        go = 1'b1;
        step();
        go = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("pause_in_wait", {31'd0, draw_req}, 32'd0);
        pause = 1'b1;
        pulses = 0;
        reqs = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (step_pulse === 1'b1) pulses++;
            if (draw_req === 1'b1) reqs++;
        end
        chk("pause_pulses", pulses, 0);
        chk("pause_reqs", reqs, 0);
        pause = 1'b0;
        step();
        chk("unpause_c1", {31'd0, step_pulse}, 32'd0);
        step();
        chk("unpause_c2", {31'd0, step_pulse}, 32'd0);
        step();
        chk("unpause_c3", {31'd0, step_pulse}, 32'd1);
        step();
        chk("unpause_erase", {31'd0, erase}, 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
